mips_div_unit: RTL and testbench
================================

Name: mips_div_unit

Overview:
- Multi-cycle integer divider implementing MIPS DIV/DIVU and writing the HI/LO pair.
- It sits beside the single-cycle CLA ALU. The ALU handles add, subtract and compare; this block handles the inverse operation of a multiply.
- Algorithm: radix-2 restoring division, one quotient bit per clock.
- Interface: start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32, operand and result width (must be even, at least 4).
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  WIDTH  rs operand
- divisor  input  WIDTH  rt operand
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; hi/lo valid from this cycle on
- div_zero  output  1  set with done when divisor was 0
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; busy=0; done=0; div_zero=0; hi=0; lo=0; internal registers cleared.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On start=1, latch the operand magnitudes, the sign of the quotient (dividend XOR divisor, signed mode only) and the sign of the remainder (dividend sign).
  - Clear the partial remainder and set the counter to WIDTH.
  - If divisor==0, go to DONE with the zero fast path. Otherwise go to CALC.
- CALC, one step per cycle:
  - trial = {rem[WIDTH-2:0], quo[WIDTH-1]} − dvsr, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem ← trial, and a 1 is shifted into quo.
  - Otherwise: rem ← shifted value, and a 0 is shifted into quo.
  - Decrement the counter; at 1, go to FIXUP.
  - CALC lasts exactly WIDTH cycles.
- FIXUP:
  - Negate quo if the quotient is negative; negate rem if the remainder is negative.
  - Register the results into lo and hi. Go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Hold: hi, lo and div_zero hold their values until the next accepted start. On the next start, div_zero clears.
- Latency, normal case: start at cycle 0 → done at cycle WIDTH+2, i.e. 34 for WIDTH=32. busy is high for cycles 1..WIDTH+1.
- Divide by zero: done at cycle 1 with div_zero=1, lo=all ones, hi=dividend (raw). This holds regardless of is_signed.
- Signed overflow (−2^(WIDTH−1) / −1): no special path. Magnitude arithmetic gives lo=0x80000000 and hi=0 naturally; the bench checks this.
- Remainder sign convention: the remainder takes the sign of the dividend; the quotient truncates toward zero (MIPS semantics).
- Start handling:
  - start while busy or in DONE: ignored, with no queueing.
  - start in the same cycle as done is ignored; the request must be reissued in IDLE.
  - Operand inputs are don't-care after the accept cycle.
- Unsigned mode: operands are used as-is; no fixup negation.

Decomposition:
- Shared package mips_div_pkg contains:
  - the state enum div_state_t (IDLE, CALC, FIXUP, DONE, 2-bit encoding);
  - the DIV_LATENCY = WIDTH+2 constant used by the control-unit stall logic and the bench.
- One sub-module: div_step. It is the combinational restoring step that takes rem, the next dividend bit and dvsr, and returns new_rem and q_bit. It is instantiated once inside the CALC datapath.
- Magnitude and negation are done with inline two's-complement logic. The ALU slices are not reused.

Test Plan:
- DIVU 100 / 7, is_signed=0 → done at cycle 34, lo=14, hi=2, div_zero=0; busy high cycles 1–33.
- DIV −100 / 7 (0xFFFFFF9C / 7) → lo=0xFFFFFFF2 (−14), hi=0xFFFFFFFE (−2). Also DIV 100 / −7 → lo=−14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, done at cycle 34. Also DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- Divisor 0 with dividend 0x1234 → done at cycle 1, div_zero=1, lo=0xFFFFFFFF, hi=0x1234. The next start of 9/3 clears div_zero and yields lo=3, hi=0.
- start pulsed during CALC at cycle 10 with different operands → ignored; the original result is returned at cycle 34. Back-to-back start issued in the cycle after done is accepted.
- rst_n asserted at cycle 20 of a division → busy=0, hi=lo=0 immediately, no done pulse. A new division after release completes normally.

Source files
------------

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU unit and the control-unit
// stall logic that waits on it.
package mips_div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvsr always holds, so the shifted value is below 2*dvsr; when its
  // top bit is set the subtraction must succeed and the low bits wrap correctly.
  always_comb begin
    shifted = {rem, in_bit};
    trial   = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvsr};
    q_bit   = shifted[WIDTH] | ~trial[WIDTH];
    new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle MIPS DIV/DIVU unit: sign-magnitude restoring division, one
// quotient bit per clock, results in HI (remainder) and LO (quotient).
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output div_state_t       dbg_state
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  div_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem_q),
    .in_bit (quo_q[WIDTH-1]),
    .dvsr   (dvsr_q),
    .new_rem(step_rem),
    .q_bit  (step_q)
  );

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? twos_neg(dividend) : dividend;
    b_mag = b_neg ? twos_neg(divisor) : divisor;
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dz_d    = 1'b0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          rem_d   = '0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          cnt_d   = CNT_INIT;
          if (divisor == '0) begin
            // Zero fast path: no iterations, raw dividend lands in HI.
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            lo_d    = '1;
            hi_d    = dividend;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIXUP;
      end
      FIXUP: begin
        lo_d    = q_neg_q ? twos_neg(quo_q) : quo_q;
        hi_d    = r_neg_q ? twos_neg(rem_q) : rem_q;
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Bench for mips_div_unit: directed vector table, randomized divisions against
// a plain-arithmetic reference, and hand-written handshake/reset sequences.
module tb_mips_div_unit;
  import mips_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  div_state_t   dbg_state;

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard entries are {div_zero, hi, lo}.
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] e_lo;
    logic [W-1:0] e_hi;
    logic         e_dz;
    int           e_lat;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  mips_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .dbg_state(dbg_state)
  );

  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb, q, r;
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a division from IDLE, waits for done (bounded), returns the cycle
  // count from the accept edge, the results seen at done, and a handshake flag.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                         output logic r_dz, output logic hs_bad);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    lat    = 1;
    hs_bad = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) hs_bad = 1'b1;
      tick();
      lat++;
    end
    if (busy) hs_bad = 1'b1;
    r_hi = hi;
    r_lo = lo;
    r_dz = div_zero;
    tick();
    if (done) hs_bad = 1'b1;
  endtask

  initial begin
    int           lat, cyc;
    logic [W-1:0] r_hi, r_lo;
    logic         r_dz, hs_bad, saw_done;
    logic [2*W:0] e;
    logic [W-1:0] ra, rb;
    logic         rs;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, DIV_LATENCY};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, DIV_LATENCY};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2,         1'b0, DIV_LATENCY};
    vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, DIV_LATENCY};
    vecs[4]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0, DIV_LATENCY};
    vecs[5]  = '{32'h00001234,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h00001234,  1'b1, 1};
    vecs[6]  = '{32'd9,         32'd3,         1'b0, 32'd3,         32'd0,         1'b0, DIV_LATENCY};
    vecs[7]  = '{32'h80000005,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h80000005,  1'b1, 1};
    vecs[8]  = '{32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 32'd1,         32'd1,         1'b0, DIV_LATENCY};
    vecs[9]  = '{32'd7,         32'd100,       1'b0, 32'd0,         32'd7,         1'b0, DIV_LATENCY};
    vecs[10] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  1'b0, DIV_LATENCY};

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed table; back-to-back issue happens naturally between entries
    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].s, lat, r_hi, r_lo, r_dz, hs_bad);
      chk($sformatf("vec%0d_lo", i), 64'(r_lo), 64'(vecs[i].e_lo));
      chk($sformatf("vec%0d_hi", i), 64'(r_hi), 64'(vecs[i].e_hi));
      chk($sformatf("vec%0d_dz", i), 64'(r_dz), 64'(vecs[i].e_dz));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].e_lat));
      chk($sformatf("vec%0d_handshake", i), 64'(hs_bad), 64'd0);
      chk($sformatf("vec%0d_hold_lo", i), 64'(lo), 64'(vecs[i].e_lo));
    end

    // start during CALC is ignored; start held through done is only taken in IDLE
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 10) begin
        dividend = 32'd50; divisor = 32'd5; is_signed = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("calc_start_lat", 64'(cyc), 64'(DIV_LATENCY));
    chk("calc_start_lo", 64'(lo), 64'd14);
    chk("calc_start_hi", 64'(hi), 64'd2);
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    tick();
    chk("done_start_ignored", 64'(busy), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, lat, r_hi, r_lo, r_dz, hs_bad);
    chk("reissue_lat", 64'(lat), 64'(DIV_LATENCY));
    chk("reissue_lo", 64'(r_lo), 64'd3);
    chk("reissue_hi", 64'(r_hi), 64'd0);

    // Reset in the middle of a division
    dividend = 32'd1000; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) rst_n = 1'b1;
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("rst_no_done", 64'(saw_done), 64'd0);
    run_div(32'd100, 32'd7, 1'b0, lat, r_hi, r_lo, r_dz, hs_bad);
    chk("post_rst_lat", 64'(lat), 64'(DIV_LATENCY));
    chk("post_rst_lo", 64'(r_lo), 64'd14);
    chk("post_rst_hi", 64'(r_hi), 64'd2);

    // Randomized divisions against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        3:       rb = '1;
        default: rb = $urandom;
      endcase
      if (i % 9 == 0) ra = 32'h80000000;
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_div(ra, rb, rs));
      run_div(ra, rb, rs, lat, r_hi, r_lo, r_dz, hs_bad);
      e = exp_q.pop_front();
      chk($sformatf("rnd%0d_lo", i), 64'(r_lo), 64'(e[W-1:0]));
      chk($sformatf("rnd%0d_hi", i), 64'(r_hi), 64'(e[2*W-1:W]));
      chk($sformatf("rnd%0d_dz", i), 64'(r_dz), 64'(e[2*W]));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), e[2*W] ? 64'd1 : 64'(DIV_LATENCY));
      chk($sformatf("rnd%0d_handshake", i), 64'(hs_bad), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
